// File: rtl/fmt_pkg.sv
// Shared types, sizes and the per-nibble add-3 helper for the BCD result formatter.
package fmt_pkg;

  localparam int unsigned WIDTH_DEF  = 7;
  localparam int unsigned DIGITS_DEF = 3;
  localparam int unsigned BCD_W      = 4 * DIGITS_DEF;
  localparam int unsigned CNT_W      = $clog2(WIDTH_DEF + 1);

  // add3_nibbles works on a fixed maximum width; callers zero-extend and truncate.
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_BCD_W  = 4 * MAX_DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Adds 3 to every nibble that is 5 or more; nibbles never carry into each other.
  function automatic logic [MAX_BCD_W-1:0] add3_nibbles(input logic [MAX_BCD_W-1:0] v);
    logic [MAX_BCD_W-1:0] r;
    logic [3:0]           nib;
    r = v;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_bcd_formatter_dd_step.sv
// One combinational double-dabble iteration: add-3 correction, then shift {acc, shift} left.
module dd_step
  import fmt_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic [4*DIGITS-1:0] acc_i,
  input  logic [WIDTH-1:0]    shift_i,
  output logic [4*DIGITS-1:0] acc_c_o,
  output logic [WIDTH-1:0]    shift_c_o
);

  localparam int unsigned ACC_W = 4 * DIGITS;

  logic [ACC_W-1:0] adj;

  // Correct digits first, then move the next binary bit into the units nibble.
  always_comb begin
    adj                    = ACC_W'(add3_nibbles(MAX_BCD_W'(acc_i)));
    {acc_c_o, shift_c_o}   = {adj, shift_i} << 1;
  end

endmodule

// File: rtl/result_bcd_formatter.sv
// Captures divider quotient/remainder and converts both to packed BCD, one bit per clock.
module result_bcd_formatter
  import fmt_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    Q_in,
  input  logic [WIDTH-1:0]    R_in,
  output logic                ready,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                done
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_B = $clog2(WIDTH + 1);

  // Digit count must cover the largest input value and fit the helper's width.
  if ((64'(10) ** DIGITS) <= ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_digits
    $error("result_bcd_formatter: DIGITS too small for WIDTH");
  end
  if (DIGITS > MAX_DIGITS) begin : g_bad_max
    $error("result_bcd_formatter: DIGITS exceeds add3_nibbles width");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_shift_q, q_shift_d;
  logic [WIDTH-1:0]   r_shift_q, r_shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_B-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   q_res_q, q_res_d;
  logic [ACC_W-1:0]   q_bcd_q, q_bcd_d;
  logic [ACC_W-1:0]   r_bcd_q, r_bcd_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   shift_src;
  logic [ACC_W-1:0]   step_acc;
  logic [WIDTH-1:0]   step_shift;
  logic               last_c;

  // Single iteration engine shared by both conversions.
  assign shift_src = (state_q == CONV_R) ? r_shift_q : q_shift_q;
  assign last_c    = (cnt_q == CNT_B'(WIDTH - 1));

  dd_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dd_step (
    .acc_i     (acc_q),
    .shift_i   (shift_src),
    .acc_c_o   (step_acc),
    .shift_c_o (step_shift)
  );

  // State register plus datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      q_shift_q <= '0;
      r_shift_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      q_res_q   <= '0;
      q_bcd_q   <= '0;
      r_bcd_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_shift_q <= q_shift_d;
      r_shift_q <= r_shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      q_res_q   <= q_res_d;
      q_bcd_q   <= q_bcd_d;
      r_bcd_q   <= r_bcd_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: start only matters in IDLE; FINISH always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CONV_Q;
      CONV_Q:  if (last_c) state_d = CONV_R;
      CONV_R:  if (last_c) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; published digits change only on entry to FINISH.
  always_comb begin
    q_shift_d = q_shift_q;
    r_shift_d = r_shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    q_res_d   = q_res_q;
    q_bcd_d   = q_bcd_q;
    r_bcd_d   = r_bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_shift_d = Q_in;
          r_shift_d = R_in;
          acc_d     = '0;
          cnt_d     = '0;
        end
      end
      CONV_Q: begin
        acc_d     = step_acc;
        q_shift_d = step_shift;
        cnt_d     = cnt_q + CNT_B'(1);
        if (last_c) begin
          q_res_d = step_acc;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CONV_R: begin
        acc_d     = step_acc;
        r_shift_d = step_shift;
        cnt_d     = cnt_q + CNT_B'(1);
        if (last_c) begin
          q_bcd_d = q_res_q;
          r_bcd_d = step_acc;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Output flags are registered copies of the upcoming state.
  always_comb begin
    ready_d = (state_d == IDLE);
    done_d  = (state_d == FINISH);
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign q_bcd = q_bcd_q;
  assign r_bcd = r_bcd_q;

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Randomised self-checking bench for result_bcd_formatter against a decimal-arithmetic model.
module tb_result_bcd_formatter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  Q_in;
  logic [6:0]  R_in;
  logic        ready;
  logic        done;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;

  int n_tests = 0;
  int n_fail  = 0;

  result_bcd_formatter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Q_in  (Q_in),
    .R_in  (R_in),
    .ready (ready),
    .q_bcd (q_bcd),
    .r_bcd (r_bcd),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [11:0] bcd_ref(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic pulse_start(input int q, input int r);
    Q_in  = 7'(q);
    R_in  = 7'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    Q_in  = 7'($urandom);
    R_in  = 7'($urandom);
  endtask

  // Waits for done; reports cycles (-1 on timeout), output stability and ready low throughout.
  task automatic wait_done(input int budget, output int cycles, output bit stable, output bit busy);
    logic [11:0] sq, sr;
    sq = q_bcd;
    sr = r_bcd;
    cycles = -1;
    stable = 1'b1;
    busy   = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
      if (q_bcd !== sq || r_bcd !== sr) stable = 1'b0;
      if (ready !== 1'b0) busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; Q_in = '0; R_in = '0;
    tick();
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags ready=%b done=%b want ready=1 done=0", ready, done);
    end
    n_tests++;
    if (q_bcd !== 12'h000 || r_bcd !== 12'h000) begin
      n_fail++; $display("FAIL reset_digits q=%h r=%h want 000/000", q_bcd, r_bcd);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle ready=%b want 1", ready);
    end
  endtask

  task automatic test_basic();
    int cyc; bit stable, busy;
    pulse_start(7, 1);
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (cyc !== 14) begin n_fail++; $display("FAIL basic_latency got %0d want 14", cyc); end
    n_tests++;
    if (q_bcd !== 12'h007 || r_bcd !== 12'h001) begin
      n_fail++; $display("FAIL basic_digits q=%h r=%h want 007/001", q_bcd, r_bcd);
    end
    n_tests++;
    if (!stable || !busy) begin
      n_fail++; $display("FAIL basic_busy stable=%b ready_low=%b want 1/1", stable, busy);
    end
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_finish_ready got %b want 0", ready); end
    tick();
    n_tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_pulse done=%b ready=%b want 0/1", done, ready);
    end
  endtask

  task automatic test_max();
    int cyc; bit stable, busy;
    pulse_start(127, 127);
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (cyc !== 14 || q_bcd !== 12'h127 || r_bcd !== 12'h127) begin
      n_fail++; $display("FAIL max_value cyc=%0d q=%h r=%h want 14 127/127", cyc, q_bcd, r_bcd);
    end
    tick();
  endtask

  task automatic test_zero_mid();
    int cyc; bit stable, busy;
    pulse_start(0, 0);
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (cyc !== 14 || q_bcd !== 12'h000 || r_bcd !== 12'h000) begin
      n_fail++; $display("FAIL zero_value cyc=%0d q=%h r=%h want 14 000/000", cyc, q_bcd, r_bcd);
    end
    tick();
    pulse_start(6, 10);
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (!stable) begin n_fail++; $display("FAIL zero_hold outputs changed before done, want held 000/000"); end
    n_tests++;
    if (cyc !== 14 || q_bcd !== 12'h006 || r_bcd !== 12'h010) begin
      n_fail++; $display("FAIL mid_value cyc=%0d q=%h r=%h want 14 006/010", cyc, q_bcd, r_bcd);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int cyc; bit stable, busy; int extra;
    pulse_start(88, 45);
    tick();
    Q_in = 7'd63; R_in = 7'd5; start = 1'b1;
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b want 0", ready); end
    tick();
    start = 1'b0;
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (cyc !== 12 || !busy) begin
      n_fail++; $display("FAIL busy_latency cyc=%0d ready_low=%b want 12/1", cyc, busy);
    end
    n_tests++;
    if (q_bcd !== bcd_ref(88) || r_bcd !== bcd_ref(45)) begin
      n_fail++; $display("FAIL busy_digits q=%h r=%h want %h/%h", q_bcd, r_bcd, bcd_ref(88), bcd_ref(45));
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    n_tests++;
    if (extra !== 0) begin n_fail++; $display("FAIL busy_not_queued extra done=%0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit stable, busy;
    pulse_start(45, 12);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0 || q_bcd !== 12'h000 || r_bcd !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid ready=%b done=%b q=%h r=%h want 1 0 000/000", ready, done, q_bcd, r_bcd);
    end
    #1;
    rst = 1'b0;
    tick();
    pulse_start(9, 3);
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (cyc !== 14 || q_bcd !== 12'h009 || r_bcd !== 12'h003) begin
      n_fail++; $display("FAIL reset_recover cyc=%0d q=%h r=%h want 14 009/003", cyc, q_bcd, r_bcd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc; bit stable, busy; int q1, r1, q2, r2;
    q1 = int'($urandom_range(0, 127)); r1 = int'($urandom_range(0, 127));
    q2 = int'($urandom_range(0, 127)); r2 = int'($urandom_range(0, 127));
    pulse_start(q1, r1);
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (cyc !== 14 || q_bcd !== bcd_ref(q1) || r_bcd !== bcd_ref(r1)) begin
      n_fail++; $display("FAIL b2b_first cyc=%0d q=%h r=%h want 14 %h/%h", cyc, q_bcd, r_bcd, bcd_ref(q1), bcd_ref(r1));
    end
    tick();
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready ready=%b done=%b want 1/0", ready, done);
    end
    pulse_start(q2, r2);
    wait_done(40, cyc, stable, busy);
    n_tests++;
    if (cyc + 2 !== 16 || q_bcd !== bcd_ref(q2) || r_bcd !== bcd_ref(r2)) begin
      n_fail++; $display("FAIL b2b_second gap=%0d q=%h r=%h want 16 %h/%h", cyc + 2, q_bcd, r_bcd, bcd_ref(q2), bcd_ref(r2));
    end
    tick();
  endtask

  task automatic test_random();
    int cyc; bit stable, busy; int q, r;
    for (int n = 0; n < 20; n++) begin
      q = int'($urandom_range(0, 127));
      r = int'($urandom_range(0, 127));
      repeat ($urandom_range(0, 3)) tick();
      pulse_start(q, r);
      wait_done(40, cyc, stable, busy);
      n_tests++;
      if (cyc !== 14 || !stable || !busy || q_bcd !== bcd_ref(q) || r_bcd !== bcd_ref(r)) begin
        n_fail++;
        $display("FAIL random_%0d Q=%0d R=%0d cyc=%0d stable=%b busy=%b q=%h r=%h want 14 1 1 %h/%h",
                 n, q, r, cyc, stable, busy, q_bcd, r_bcd, bcd_ref(q), bcd_ref(r));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_mid();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_bcd_formatter.md
Name: result_bcd_formatter

Overview:
- Downstream consumer of divisor_restoring. Captures the 7-bit quotient and remainder when the divider pulses done.
- Converts each value sequentially to packed BCD using double-dabble (shift / add-3), one bit per clock. Quotient is converted first, then remainder.
- Presents stable BCD digits plus a one-cycle done pulse to the display/UART stage further downstream.

Parameters:
- WIDTH, 7, bit width of the Q/R inputs; must match the divider.
- DIGITS, 3, BCD digits per value; must satisfy 10**DIGITS > 2**WIDTH-1. Checked by an elaboration-time assertion.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  capture strobe; wired to divider done.
- Q_in  in  WIDTH  quotient from divider.
- R_in  in  WIDTH  remainder from divider.
- ready  out  1  high only in IDLE; start is accepted only when ready=1.
- q_bcd  out  4*DIGITS  quotient BCD; digit 0 in bits [3:0] (units).
- r_bcd  out  4*DIGITS  remainder BCD, same packing.
- done  out  1  single-cycle pulse; q_bcd/r_bcd are new and valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ready=1, done=0, q_bcd=0, r_bcd=0, all internal shift/bit counters cleared.
  - Reset mid-conversion aborts immediately; outputs return to 0.
- FSM states: IDLE, CONV_Q, CONV_R, FINISH.
- IDLE:
  - start=1 at edge k: latch Q_in/R_in into shift registers, clear the BCD accumulator, bit counter=0, go to CONV_Q.
  - start=0: stay.
- CONV_Q, one iteration per edge:
  - Every BCD nibble >=5 gets +3.
  - Then shift {acc, q_shift} left 1.
  - Counter increments.
  - On the WIDTH-th iteration (edge k+WIDTH): store acc into an internal q result, clear acc and counter, go to CONV_R.
- CONV_R: identical, on the remainder shift register. On edge k+2*WIDTH: q_bcd <= q result, r_bcd <= final acc, go to FINISH.
- FINISH:
  - done=1 for exactly this one cycle; ready=0.
  - Next edge always goes to IDLE.
  - A start during FINISH is ignored, not queued.
- Latency: done is high in the cycle after edge k+2*WIDTH, i.e. 14 cycles after the capture edge for WIDTH=7. Minimum start-to-start spacing is 2*WIDTH+2 cycles.
- start while ready=0 (CONV_Q, CONV_R, FINISH): ignored. Q_in/R_in changes are ignored after capture.
- q_bcd and r_bcd are updated only at the FINISH transition. They hold their previous values throughout a conversion, so there are no glitches downstream.
- Width rules:
  - Accumulator is 4*DIGITS bits.
  - Add-3 is applied per nibble on 4-bit values; no carry between nibbles.
  - Bit counter is $clog2(WIDTH+1) bits.
  - All inputs are unsigned.
- Boundary values:
  - 0 yields all-zero digits.
  - 127 yields 1,2,7.
  - Remainder is always < quotient range, but both paths are converted identically with no special-casing.

Decomposition:
- Package fmt_pkg holds:
  - state enum typedef (IDLE, CONV_Q, CONV_R, FINISH);
  - localparams BCD_W = 4*DIGITS and CNT_W;
  - function add3_nibbles (per-nibble conditional +3 over a packed BCD vector).
- One sub-module, dd_step: combinational, one double-dabble iteration taking {acc, shift} and producing the next {acc, shift}, parameterised by WIDTH and DIGITS. It is instantiated once and shared between CONV_Q and CONV_R through a mux on the shift source.

Test Plan:
- Basic: Q_in=7, R_in=1 (50/7), pulse start -> done exactly 14 cycles later; q_bcd=12'h007, r_bcd=12'h001; done high one cycle only.
- Max value: Q_in=127, R_in=127 -> q_bcd=12'h127, r_bcd=12'h127.
- Zero and mid-range: Q_in=0, R_in=0 -> 12'h000/12'h000; then Q_in=6, R_in=10 (100/15) -> 12'h006/12'h010; q_bcd/r_bcd hold 000/000 until the second done.
- Busy-ignore: second start pulse 3 cycles after first, with different Q_in=63 -> ignored; result matches the first capture; ready=0 throughout.
- Reset mid-op: assert rst at cycle 5 of a conversion -> outputs 0, ready=1 asynchronously; after release, a new start (Q=9, R=3) converts correctly.
- Back-to-back: start reasserted the cycle ready returns -> two done pulses 16 cycles apart, each with correct digits.
